// File: rtl/alu_pipe_cc.sv
// Two-stage pipelined ALU (ADD/SUB/AND/XOR) with valid/ready handshakes and an
// architectural {ZF,SF,OF} condition-code register that drives jXX/cmovXX conditions.
`timescale 1ns/1ps

module alu_pipe_cc #(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             sign,
  output logic             overflow,
  input  logic [2:0]       cond_fn,
  output logic             cond,
  output logic [2:0]       cc
);

  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  // Stage 1: captured operands
  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_set_cc_q, s1_set_cc_d;

  // Stage 2: result and its flags, presented at the output
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             overflow_q, overflow_d;
  logic             s2_set_cc_q, s2_set_cc_d;

  logic [2:0]       cc_q, cc_d;

  logic             s2_load, in_fire, retire;
  logic [WIDTH-1:0] alu_res;
  logic             alu_of;

  assign s2_load  = !s2_valid_q || out_ready;
  assign in_ready = !flush && (!s1_valid_q || !s2_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign retire   = s2_valid_q && out_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    alu_res = '0;
    alu_of  = 1'b0;
    unique case (s1_op_q)
      OP_ADD: begin
        alu_res = s1_a_q + s1_b_q;
        alu_of  = (s1_a_q[MSB] == s1_b_q[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        alu_res = s1_a_q - s1_b_q;
        alu_of  = (s1_a_q[MSB] != s1_b_q[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      OP_AND: alu_res = s1_a_q & s1_b_q;
      OP_XOR: alu_res = s1_a_q ^ s1_b_q;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_set_cc_d = s1_set_cc_q;
    s2_valid_d  = s2_valid_q;
    res_d       = res_q;
    zero_d      = zero_q;
    sign_d      = sign_q;
    overflow_d  = overflow_q;
    s2_set_cc_d = s2_set_cc_q;
    cc_d        = cc_q;

    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_fire) begin
      s1_valid_d  = 1'b1;
      s1_op_d     = op_e'(opcode);
      s1_a_d      = a;
      s1_b_d      = b;
      s1_set_cc_d = set_cc;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    // Result registers keep their last value when the stage empties or is flushed.
    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d       = alu_res;
        zero_d      = (alu_res == '0);
        sign_d      = alu_res[MSB];
        overflow_d  = alu_of;
        s2_set_cc_d = s1_set_cc_q;
      end
    end

    // A retiring op was seen by the consumer, so it commits even during a flush.
    if (retire && s2_set_cc_q) begin
      cc_d = {zero_q, sign_q, overflow_q};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_set_cc_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      sign_q      <= 1'b0;
      overflow_q  <= 1'b0;
      s2_set_cc_q <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_set_cc_q <= s1_set_cc_d;
      s2_valid_q  <= s2_valid_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      sign_q      <= sign_d;
      overflow_q  <= overflow_d;
      s2_set_cc_q <= s2_set_cc_d;
      cc_q        <= cc_d;
    end
  end

  // Condition evaluation reads only the committed CC register, never in-flight ops.
  always_comb begin
    cond = 1'b0;
    unique case (cond_fn)
      3'd0: cond = 1'b1;
      3'd1: cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      3'd2: cond = cc_q[1] ^ cc_q[0];
      3'd3: cond = cc_q[2];
      3'd4: cond = !cc_q[2];
      3'd5: cond = !(cc_q[1] ^ cc_q[0]);
      3'd6: cond = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
      3'd7: cond = 1'b0;
    endcase
  end

  assign out_valid = s2_valid_q;
  assign res       = res_q;
  assign zero      = zero_q;
  assign sign      = sign_q;
  assign overflow  = overflow_q;
  assign cc        = cc_q;

endmodule

// File: tb/tb_alu_pipe_cc.sv
// Randomized scoreboard bench for alu_pipe_cc: a driver pushes expected results from an
// arithmetic reference model; a monitor pops and compares on every output beat.
`timescale 1ns/1ps

module tb_alu_pipe_cc;

  localparam int         W      = 64;
  localparam logic [2:0] CC_RST = 3'b100;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         s;
    logic         o;
    logic         sc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   opcode = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         set_cc = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] res;
  logic         zero, sign, overflow;
  logic [2:0]   cond_fn = 3'd3;
  logic         cond;
  logic [2:0]   cc;

  // Narrow instance for the 8-bit boundary cases
  logic         in_valid8 = 1'b0;
  logic         in_ready8;
  logic [1:0]   op8 = 2'd0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic         out_valid8;
  logic [7:0]   res8;
  logic         z8, s8, o8, cond8;
  logic [2:0]   cc8;

  exp_t       q[$];
  logic [2:0] cc_m = CC_RST;
  int         errors = 0;
  int         checks = 0;
  int         bp_mode = 0;

  always #5 clk = ~clk;

  alu_pipe_cc #(.WIDTH(W), .CC_RESET(CC_RST)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .set_cc(set_cc), .out_valid(out_valid),
    .out_ready(out_ready), .res(res), .zero(zero), .sign(sign), .overflow(overflow),
    .cond_fn(cond_fn), .cond(cond), .cc(cc)
  );

  alu_pipe_cc #(.WIDTH(8), .CC_RESET(CC_RST)) dut8 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid8), .in_ready(in_ready8),
    .opcode(op8), .a(a8), .b(b8), .set_cc(1'b1), .out_valid(out_valid8),
    .out_ready(1'b1), .res(res8), .zero(z8), .sign(s8), .overflow(o8),
    .cond_fn(3'd0), .cond(cond8), .cc(cc8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Signed overflow means the exact signed result does not fit in W bits.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sc);
    exp_t e;
    logic signed [W:0] wide, hi, lo;
    hi = {2'b00, {(W-1){1'b1}}};
    lo = {2'b11, {(W-1){1'b0}}};
    e.o = 1'b0;
    case (op)
      2'd0: begin
        wide  = $signed({x[W-1], x}) + $signed({y[W-1], y});
        e.res = wide[W-1:0];
        e.o   = (wide > hi) || (wide < lo);
      end
      2'd1: begin
        wide  = $signed({x[W-1], x}) - $signed({y[W-1], y});
        e.res = wide[W-1:0];
        e.o   = (wide > hi) || (wide < lo);
      end
      2'd2:    e.res = x & y;
      default: e.res = x ^ y;
    endcase
    e.z  = (e.res == '0);
    e.s  = e.res[W-1];
    e.sc = sc;
    return e;
  endfunction

  function automatic logic cond_ref(input logic [2:0] c, input logic [2:0] fn);
    logic zf, sf, of_, less;
    zf   = c[2];
    sf   = c[1];
    of_  = c[0];
    less = (sf != of_);
    case (fn)
      3'd0:    return 1'b1;
      3'd1:    return less || zf;
      3'd2:    return less;
      3'd3:    return zf;
      3'd4:    return !zf;
      3'd5:    return !less;
      3'd6:    return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b0, {(W-1){1'b1}}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic sc);
    int waited = 0;
    opcode   = op;
    a        = x;
    b        = y;
    set_cc   = sc;
    cond_fn  = 3'($urandom_range(0, 7));
    in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 200) begin
      @(posedge clk);
      #2;
      waited++;
    end
    check("issue_accept", in_ready, 1);
    if (in_ready) q.push_back(model(op, x, y, sc));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush    = 1'b1;
    in_valid = 1'b1;
    opcode   = 2'($urandom_range(0, 3));
    a        = rnd_word();
    b        = rnd_word();
    set_cc   = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 64'(q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string nm, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                      input logic [7:0] er, input logic ez, input logic es, input logic eo);
    int n = 0;
    op8       = op;
    a8        = x;
    b8        = y;
    in_valid8 = 1'b1;
    #1;
    check({nm, "_in_ready"}, in_ready8, 1);
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    while (!out_valid8 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, "_valid"}, out_valid8, 1);
    check({nm, "_res"}, res8, er);
    check({nm, "_flags"}, {z8, s8, o8}, {ez, es, eo});
    @(posedge clk);
    #1;
  endtask

  // Consumer-side ready, updated early in each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #0.5;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every presented result against the oldest expected one.
  initial begin
    logic         stall;
    logic [W-1:0] pres;
    logic [2:0]   pflags;
    exp_t         e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q.delete();
        cc_m  = CC_RST;
        stall = 1'b0;
      end else begin
        check("cc", cc, cc_m);
        check("cond", cond, cond_ref(cc_m, cond_fn));
        if (stall) begin
          check("hold_res", res, pres);
          check("hold_flags", {zero, sign, overflow}, pflags);
        end
        if (out_valid) begin
          if (q.size() == 0) begin
            check("spurious_out_valid", out_valid, 0);
          end else begin
            e = q[0];
            check("res", res, e.res);
            check("flags", {zero, sign, overflow}, {e.z, e.s, e.o});
            if (out_ready) begin
              void'(q.pop_front());
              if (e.sc) cc_m = {e.z, e.s, e.o};
            end
          end
        end
        stall  = out_valid && !out_ready;
        pres   = res;
        pflags = {zero, sign, overflow};
        if (flush) q.delete();
      end
    end
  end

  initial begin
    logic [2:0] cc_before;

    // Power-up reset, released mid-cycle
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_cc", cc, CC_RST);
    check("rst_cond_e", cond, 1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Signed overflow on ADD
    issue(2'd0, {1'b0, {(W-1){1'b1}}}, 64'd1, 1'b1);
    drain();
    check("add_ovf_cc", cc, 3'b011);
    cond_fn = 3'd2;
    #1;
    check("add_ovf_cond_l", cond, 0);
    cond_fn = 3'd1;
    #1;
    check("add_ovf_cond_le", cond, 0);

    // Back-to-back SUB (sets CC) and XOR (does not)
    issue(2'd1, 64'd5, 64'd5, 1'b1);
    issue(2'd3, 64'hF0, 64'h0F, 1'b0);
    drain();
    check("sub_xor_cc", cc, 3'b100);

    // Backpressure: four ADDs while the consumer stalls
    bp_mode = 2;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 1; i <= 4; i++) issue(2'd0, 64'(i), 64'(i), 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_res_head", res, 64'd2);
        bp_mode = 0;
      end
    join
    drain();

    // Flush with both stages full and a beat offered
    bp_mode = 2;
    @(posedge clk);
    #1;
    issue(2'd0, 64'd10, 64'd20, 1'b1);
    issue(2'd1, 64'd7, 64'd9, 1'b1);
    check("pre_flush_in_ready", in_ready, 0);
    cc_before = cc;
    do_flush();
    check("flush_out_valid", out_valid, 0);
    check("flush_cc", cc, cc_before);
    bp_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    check("flush_stays_empty", out_valid, 0);

    // Randomized traffic with random consumer stalls and occasional flushes
    bp_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) do_flush();
      else issue(2'($urandom_range(0, 3)), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    bp_mode = 0;
    drain();

    // Asynchronous reset in the middle of a cycle with ops in flight
    bp_mode = 2;
    @(posedge clk);
    #1;
    issue(2'd0, 64'd1, 64'd2, 1'b1);
    issue(2'd1, 64'd0, 64'd1, 1'b1);
    cond_fn = 3'd3;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_cc", cc, CC_RST);
    check("midrst_cond_e", cond, 1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    bp_mode = 0;
    @(posedge clk);
    #1;

    // 8-bit boundaries
    run8("w8_sub", 2'd1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
    check("w8_sub_cc", cc8, 3'b001);
    run8("w8_and", 2'd2, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0);
    check("w8_and_cc", cc8, 3'b100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
